mips_mem_arbiter: RTL
=====================

MIPS_MEM_ARBITER -- requirements
Module: mips_mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, memory word-address width (1024 words).
REQ-002 The block SHALL have parameter DATA_W, default 32, memory word width.
REQ-003 The block SHALL have parameter STARVE_LIMIT, default 4, number of consecutive denied fetch cycles before fetch promotion.
REQ-004 The block SHALL have port clk1  in  1  single clock; all state changes on posedge.
REQ-005 The block SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 The block SHALL have port halted  in  1  pipeline HALT state; high restricts service to the debug port.
REQ-007 The block SHALL have ports if_req/if_addr  in  1/ADDR_W  instruction-fetch read request.
REQ-008 The block SHALL have ports dm_req/dm_we/dm_addr/dm_wdata  in  1/1/ADDR_W/DATA_W  data-memory load/store request.
REQ-009 The block SHALL have ports dbg_req/dbg_we/dbg_addr/dbg_wdata  in  1/1/ADDR_W/DATA_W  program-loader/debug request.
REQ-010 The block SHALL have ports if_gnt, dm_gnt, dbg_gnt  out  1 each  same-cycle grant; one-hot or all zero.
REQ-011 The block SHALL have ports if_rvalid, dm_rvalid, dbg_rvalid  out  1 each  read data valid on rdata for that port.
REQ-012 The block SHALL have port rdata  out  DATA_W  shared read-return data.
REQ-013 The block SHALL have ports mem_en/mem_we/mem_addr/mem_wdata  out  1/1/ADDR_W/DATA_W  single-port memory command.
REQ-014 The block SHALL have port mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_en with mem_we=0.

Function
REQ-015 Grants SHALL be combinational from current requests and registered state; exactly one access SHALL be issued per cycle at most.
REQ-016 FSM states SHALL be RUN and HALT; RUN->HALT on a cycle sampling halted=1, HALT->RUN on a cycle sampling halted=0.
REQ-017 In RUN, priority SHALL be dbg > dm > if, except as modified by REQ-023.
REQ-018 In HALT, and in any cycle where halted=1, only dbg SHALL be grantable; if_gnt and dm_gnt SHALL be 0.
REQ-019 A granted request SHALL drive mem_en=1 and the winner's we/addr/wdata the same cycle; if requests never write (mem_we=0).
REQ-020 A granted read SHALL assert that port's rvalid exactly one cycle later with rdata=mem_rdata; writes SHALL produce no rvalid.
REQ-021 Back-to-back grants SHALL be allowed every cycle; sustained throughput one access/cycle.
REQ-022 Ungranted requesters SHALL hold req and operands stable until granted; the arbiter SHALL NOT queue requests.
REQ-023 A starvation counter SHALL increment each cycle if_req=1 and if_gnt=0 in RUN, saturate at STARVE_LIMIT, and clear on if_gnt or if_req=0.
REQ-024 Simultaneous dm and dbg write to one address SHALL resolve by priority; only the winner writes that cycle.
REQ-025 When no request is granted, mem_en SHALL be 0 and mem_we/mem_addr/mem_wdata SHALL be 0.

Reset
REQ-026 reset SHALL force state RUN, starvation counter 0, all rvalid 0, rdata 0.
REQ-027 A read granted in the cycle before reset SHALL NOT produce rvalid after reset; reset SHALL dominate all other inputs.
REQ-028 During reset all gnt and mem_en outputs SHALL be 0.

Configuration
REQ-029 With FETCH_FAIRNESS_EN defined, when the starvation counter equals STARVE_LIMIT and halted=0, if SHALL outrank dm (dbg still highest) for that cycle.
REQ-030 Without FETCH_FAIRNESS_EN, priority SHALL be strict dbg > dm > if; the counter SHALL still be maintained but SHALL NOT affect grants.

Structure
REQ-031 Requester IDs (IF, DM, DBG), FSM state encoding and default parameter values SHALL live in shared package mips_mem_pkg.
REQ-032 Priority selection SHALL be a sub-module mips_prio_sel (3-input request vector, promote flag -> one-hot grant); the rest is one module.

Verification
REQ-033 Scenario: reset, then if_req=1 addr=5 alone -> if_gnt=1, mem_addr=5, if_rvalid=1 next cycle with rdata=Mem[5].
REQ-034 Scenario: if_req and dm_req (read addr 20) together, strict build -> dm_gnt=1 and if_gnt=0; if_gnt=1 the following cycle once dm_req drops.
REQ-035 Scenario: FETCH_FAIRNESS_EN, if_req and dm_req held high 6 cycles -> dm granted cycles 1-4, if granted cycle 5, dm cycle 6.
REQ-036 Scenario: halted=1 with if_req, dm_req, dbg_req (write addr 3, 0xDEADBEEF) -> only dbg_gnt; Mem[3]=0xDEADBEEF; no if/dm grants until halted=0.
REQ-037 Scenario: dm read granted at cycle N, reset at N+1 -> dm_rvalid stays 0 at N+1 and after.
REQ-038 Scenario: alternating dbg write addr 7=0x11 then dm read addr 7 on consecutive cycles -> dm_rvalid with rdata=0x11.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS memory arbiter: requester IDs, arbiter
// state encoding and default parameter values.
package mips_mem_pkg;

  localparam int unsigned ADDR_W_DEF       = 10;
  localparam int unsigned DATA_W_DEF       = 32;
  localparam int unsigned STARVE_LIMIT_DEF = 4;
  localparam int unsigned NUM_REQ          = 3;

  // Bit position of each requester in request/grant vectors
  typedef enum logic [1:0] {
    REQ_IF  = 2'd0,
    REQ_DM  = 2'd1,
    REQ_DBG = 2'd2
  } req_id_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mips_prio_sel.sv
// Fixed-priority selector: dbg > dm > if, with fetch promoted above dm when
// i_promote is set. Produces a one-hot (or all-zero) grant vector.
//   i_req     : request vector indexed by req_id_e
//   i_promote : raise fetch above data-memory for this cycle
//   o_gnt     : one-hot grant vector indexed by req_id_e
module mips_prio_sel
  import mips_mem_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_promote,
  output logic [NUM_REQ-1:0] o_gnt
);

  always_comb begin
    o_gnt = '0;
    if (i_req[REQ_DBG])                  o_gnt[REQ_DBG] = 1'b1;
    else if (i_promote && i_req[REQ_IF]) o_gnt[REQ_IF]  = 1'b1;
    else if (i_req[REQ_DM])              o_gnt[REQ_DM]  = 1'b1;
    else if (i_req[REQ_IF])              o_gnt[REQ_IF]  = 1'b1;
  end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Single-port memory arbiter for a MIPS core: instruction fetch, data memory
// and a debug/program-loader port share one synchronous memory.
// Optional feature macro: FETCH_FAIRNESS_EN (starved fetch outranks dm).
// Ports:
//   clk1, reset                  clock, synchronous active-high reset
//   halted                       pipeline halt; only dbg served while set
//   if_*/dm_*/dbg_*              requester interfaces
//   *_gnt                        same-cycle grants (one-hot or zero)
//   *_rvalid, rdata              read return, one cycle after grant
//   mem_en/we/addr/wdata         memory command, mem_rdata read data
module mips_mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk1,
  input  logic              reset,
  input  logic              halted,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              if_gnt,
  output logic              dm_gnt,
  output logic              dbg_gnt,
  output logic              if_rvalid,
  output logic              dm_rvalid,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

`ifdef FETCH_FAIRNESS_EN
  localparam bit FAIR_EN = 1'b1;
`else
  localparam bit FAIR_EN = 1'b0;
`endif

  arb_state_e         r_state;
  arb_state_e         w_state_nxt;
  logic               w_run_ok;
  logic [CNT_W-1:0]   r_starve_cnt;
  logic               w_starved;
  logic               w_promote;
  logic [NUM_REQ-1:0] w_req;
  logic [NUM_REQ-1:0] w_gnt;
  logic               r_if_rvalid;
  logic               r_dm_rvalid;
  logic               r_dbg_rvalid;
  logic               w_any_rvalid;

  // State register
  always_ff @(posedge clk1) begin
    if (reset) r_state <= ST_RUN;
    else       r_state <= w_state_nxt;
  end

  // Next state; if/dm are grantable only in RUN while halted is low
  always_comb begin
    w_state_nxt = r_state;
    w_run_ok    = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_run_ok = ~halted;
        if (halted) w_state_nxt = ST_HALT;
      end
      ST_HALT: begin
        if (!halted) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // Requests qualified by state; reset blocks every grant
  always_comb begin
    w_req          = '0;
    w_req[REQ_IF]  = if_req  & w_run_ok & ~reset;
    w_req[REQ_DM]  = dm_req  & w_run_ok & ~reset;
    w_req[REQ_DBG] = dbg_req & ~reset;
  end

  assign w_starved = (r_starve_cnt == CNT_W'(STARVE_LIMIT));
  // Counter is kept in both builds; only the fairness build lets it steer grants
  assign w_promote = FAIR_EN & w_starved & ~halted;

  mips_prio_sel u_prio_sel (
    .i_req     (w_req),
    .i_promote (w_promote),
    .o_gnt     (w_gnt)
  );

  assign if_gnt  = w_gnt[REQ_IF];
  assign dm_gnt  = w_gnt[REQ_DM];
  assign dbg_gnt = w_gnt[REQ_DBG];

  // Memory command mux; idle cycles drive an all-zero command
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (dbg_gnt) begin
      mem_en    = 1'b1;
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end else if (dm_gnt) begin
      mem_en    = 1'b1;
      mem_we    = dm_we;
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end else if (if_gnt) begin
      mem_en    = 1'b1;
      mem_addr  = if_addr;
    end
  end

  // Fetch starvation counter: counts denied RUN cycles, saturates at the limit
  always_ff @(posedge clk1) begin
    if (reset) begin
      r_starve_cnt <= '0;
    end else if (!if_req || if_gnt) begin
      r_starve_cnt <= '0;
    end else if (r_state == ST_RUN && !w_starved) begin
      r_starve_cnt <= r_starve_cnt + CNT_W'(1);
    end
  end

  // Read-return tags, one cycle behind the grant
  always_ff @(posedge clk1) begin
    if (reset) begin
      r_if_rvalid  <= 1'b0;
      r_dm_rvalid  <= 1'b0;
      r_dbg_rvalid <= 1'b0;
    end else begin
      r_if_rvalid  <= if_gnt;
      r_dm_rvalid  <= dm_gnt & ~dm_we;
      r_dbg_rvalid <= dbg_gnt & ~dbg_we;
    end
  end

  // Reset masks returns immediately so a read issued just before reset is dropped
  assign if_rvalid    = r_if_rvalid  & ~reset;
  assign dm_rvalid    = r_dm_rvalid  & ~reset;
  assign dbg_rvalid   = r_dbg_rvalid & ~reset;
  assign w_any_rvalid = if_rvalid | dm_rvalid | dbg_rvalid;
  assign rdata        = w_any_rvalid ? mem_rdata : '0;

endmodule
